// File: rtl/video_mode_pkg.sv
// rtl/video_mode_pkg.sv - shared constants and state encoding for video_mode_ctrl
package video_mode_pkg;

  localparam logic [20:0] CFG_ADDR_DEFAULT = 21'h008FD5;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_SCROLL  = 8'h7E;
  localparam logic [7:0] SC_NUMLOCK = 8'h77;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/video_mode_ctrl_ps2_rx.sv
// rtl/video_mode_ctrl_ps2_rx.sv - passive PS/2 receiver with clock glitch filter and frame timeout
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int PS2_TIMEOUT = 6000
) (
  input  logic       clk6,
  input  logic       master_reset_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int TW = $clog2(PS2_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(PS2_TIMEOUT);

  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic [1:0]            data_sync;
  logic [3:0]            bit_cnt;
  logic [9:0]            shift;
  logic [TW-1:0]         idle_cnt;
  logic                  fall;
  logic                  rise;

  // Filtered level only flips once the whole window agrees
  assign fall = filt_clk & ~(|filt_sr);
  assign rise = ~filt_clk & (&filt_sr);

  always_ff @(posedge clk6) begin
    if (!master_reset_n) begin
      filt_sr   <= '1;
      filt_clk  <= 1'b1;
      data_sync <= 2'b11;
      bit_cnt   <= 4'd0;
      shift     <= 10'd0;
      idle_cnt  <= '0;
      rx_byte   <= 8'd0;
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], clkps2};
      data_sync <= {data_sync[0], dataps2};
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;

      if (fall) filt_clk <= 1'b0;
      if (rise) filt_clk <= 1'b1;

      if (fall || rise) idle_cnt <= '0;
      else if (idle_cnt != TMO) idle_cnt <= idle_cnt + TW'(1);

      // shift[0] is the start bit, shift[8:1] data, shift[9] parity
      if (fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (!shift[0] && data_sync[1] && (^shift[9:1])) begin
            rx_byte   <= shift[8:1];
            rx_strobe <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end else begin
          shift   <= {data_sync[1], shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (idle_cnt == TMO) begin
        bit_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - boot-time SRAM config read and PS/2 hotkey control of scandoubler mode
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter logic [20:0] CFG_ADDR      = CFG_ADDR_DEFAULT,
  parameter int          SETTLE_CYCLES = 64,
  parameter int          PS2_TIMEOUT   = 6000,
  parameter int          FILTER_LEN    = 8
) (
  input  logic        clk6,
  input  logic        master_reset_n,
  input  logic        clkps2,
  input  logic        dataps2,
  input  logic [7:0]  sram_data_in,
  output logic [20:0] cfg_addr,
  output logic        cfg_rd_active,
  output logic        cfg_done,
  output logic        enable_scandoubling,
  output logic        disable_scaneffect
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  ctrl_state_t   state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode;
  logic          held_sl;
  logic          held_nl;
  logic          brk;
  logic          ext;
  logic [7:0]    rx_byte;
  logic          rx_strobe;
  logic          rx_err;
  logic          unused_sram_bits;

  assign cfg_addr         = CFG_ADDR;
  assign unused_sram_bits = ^sram_data_in[7:2];

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .PS2_TIMEOUT (PS2_TIMEOUT)
  ) u_ps2_rx (
    .clk6           (clk6),
    .master_reset_n (master_reset_n),
    .clkps2         (clkps2),
    .dataps2        (dataps2),
    .rx_byte        (rx_byte),
    .rx_strobe      (rx_strobe),
    .rx_err         (rx_err)
  );

  always_ff @(posedge clk6) begin
    if (!master_reset_n) begin
      state               <= BOOT;
      cnt                 <= '0;
      mode                <= 2'b00;
      held_sl             <= 1'b0;
      held_nl             <= 1'b0;
      brk                 <= 1'b0;
      ext                 <= 1'b0;
      cfg_rd_active       <= 1'b1;
      cfg_done            <= 1'b0;
      enable_scandoubling <= 1'b0;
      disable_scaneffect  <= 1'b1;
    end else begin
      enable_scandoubling <= mode[0];
      disable_scaneffect  <= ~mode[1];
      case (state)
        // Receiver traffic during the boot read is dropped, including the transition cycle
        BOOT: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            mode          <= sram_data_in[1:0];
            state         <= RUN;
            cfg_rd_active <= 1'b0;
            cfg_done      <= 1'b1;
          end
        end
        RUN: begin
          if (rx_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
          end else if (rx_strobe) begin
            if (rx_byte == SC_BREAK) begin
              brk <= 1'b1;
            end else if (rx_byte == SC_EXT) begin
              ext <= 1'b1;
            end else begin
              brk <= 1'b0;
              ext <= 1'b0;
              // Extended finals (E0 7E is Ctrl+Break) never touch the mode
              if (!ext && rx_byte == SC_SCROLL) begin
                if (brk) held_sl <= 1'b0;
                else if (!held_sl) begin
                  mode[0] <= ~mode[0];
                  held_sl <= 1'b1;
                end
              end else if (!ext && rx_byte == SC_NUMLOCK) begin
                if (brk) held_nl <= 1'b0;
                else if (!held_nl) begin
                  mode[1] <= ~mode[1];
                  held_nl <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - self-checking bench for video_mode_ctrl
module tb_video_mode_ctrl;

  localparam int HALF = 20;

  logic        clk6 = 1'b0;
  logic        master_reset_n = 1'b0;
  logic        clkps2 = 1'b1;
  logic        dataps2 = 1'b1;
  logic [7:0]  sram_data_in = 8'h00;
  logic [20:0] cfg_addr;
  logic        cfg_rd_active;
  logic        cfg_done;
  logic        enable_scandoubling;
  logic        disable_scaneffect;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_edges = 0;
  int   err_cnt = 0;
  bit   chk_en = 1'b0;
  logic [1:0] mode_m = 2'b00;
  bit   hsl_m, hnl_m, brk_m, ext_m;

  video_mode_ctrl dut (
    .clk6                (clk6),
    .master_reset_n      (master_reset_n),
    .clkps2              (clkps2),
    .dataps2             (dataps2),
    .sram_data_in        (sram_data_in),
    .cfg_addr            (cfg_addr),
    .cfg_rd_active       (cfg_rd_active),
    .cfg_done            (cfg_done),
    .enable_scandoubling (enable_scandoubling),
    .disable_scaneffect  (disable_scaneffect)
  );

  always #5 clk6 = ~clk6;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rising edges since reset release; the boot read spans the first 64 of them
  always @(posedge clk6) begin
    if (!master_reset_n) n_edges = 0;
    else n_edges++;
  end

  always @(negedge clk6) if (dut.rx_err === 1'b1) err_cnt++;

  always @(negedge clk6) begin
    if (chk_en) begin
      check("cmp_rd_active", {31'd0, cfg_rd_active}, {31'd0, n_edges < 64});
      check("cmp_done", {31'd0, cfg_done}, {31'd0, n_edges >= 64});
      check("cmp_en", {31'd0, enable_scandoubling}, {31'd0, (n_edges >= 65) ? mode_m[0] : 1'b0});
      check("cmp_dis", {31'd0, disable_scaneffect}, {31'd0, (n_edges >= 65) ? ~mode_m[1] : 1'b1});
    end
  end

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hF0) brk_m = 1;
    else if (b == 8'hE0) ext_m = 1;
    else begin
      if (!ext_m && b == 8'h7E) begin
        if (brk_m) hsl_m = 0;
        else if (!hsl_m) begin mode_m[0] = ~mode_m[0]; hsl_m = 1; end
      end
      if (!ext_m && b == 8'h77) begin
        if (brk_m) hnl_m = 0;
        else if (!hnl_m) begin mode_m[1] = ~mode_m[1]; hnl_m = 1; end
      end
      brk_m = 0;
      ext_m = 0;
    end
  endfunction

  task automatic do_reset(input logic [7:0] val, input int hold);
    chk_en = 0;
    sram_data_in = val;
    master_reset_n = 0;
    repeat (hold) @(negedge clk6);
    check("reset_vals", {28'd0, enable_scandoubling, disable_scaneffect, cfg_rd_active, cfg_done}, 32'b0110);
    mode_m = val[1:0];
    hsl_m = 0; hnl_m = 0; brk_m = 0; ext_m = 0;
    master_reset_n = 1;
    chk_en = 1;
  endtask

  task automatic boot_len(input string nm);
    int c = 0;
    while (cfg_rd_active && c < 200) begin
      @(negedge clk6);
      c++;
    end
    check(nm, c, 64);
    repeat (3) @(negedge clk6);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dataps2 = fr[i];
      repeat (HALF) @(negedge clk6);
      clkps2 = 0;
      repeat (HALF) @(negedge clk6);
      clkps2 = 1;
    end
    dataps2 = 1;
    repeat (14) @(negedge clk6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk_en = 0;
    send_frame(b, 1'b0, 11);
    model_byte(b);
    chk_en = 1;
    repeat (4) @(negedge clk6);
  endtask

  initial begin
    @(negedge clk6);
    do_reset(8'h03, 3);
    check("cfg_addr", {11'd0, cfg_addr}, 32'h008FD5);
    boot_len("boot_len_03");
    check("boot_03_outs", {29'd0, enable_scandoubling, disable_scaneffect, cfg_done}, 32'b101);

    do_reset(8'h02, 2);
    repeat (30) @(negedge clk6);
    do_reset(8'h02, 2);
    boot_len("boot_len_02");
    check("boot_02_outs", {29'd0, enable_scandoubling, disable_scaneffect, cfg_done}, 32'b001);

    do_reset(8'h00, 2);
    boot_len("boot_len_00");

    send_byte(8'h7E);
    check("sl_first", {31'd0, enable_scandoubling}, 32'd1);
    send_byte(8'h7E);
    send_byte(8'h7E);
    check("sl_typematic", {31'd0, enable_scandoubling}, 32'd1);
    send_byte(8'hF0);
    send_byte(8'h7E);
    send_byte(8'h7E);
    check("sl_back", {31'd0, enable_scandoubling}, 32'd0);

    send_byte(8'h77);
    check("nl_toggle", {31'd0, disable_scaneffect}, 32'd0);
    send_byte(8'hE0);
    send_byte(8'h7E);
    check("ext_ignored", {30'd0, enable_scandoubling, disable_scaneffect}, 32'b00);

    send_byte(8'hF0);
    send_byte(8'h7E);
    chk_en = 0;
    send_frame(8'h7E, 1'b1, 11);
    brk_m = 0; ext_m = 0;
    chk_en = 1;
    repeat (4) @(negedge clk6);
    check("parity_err_cnt", err_cnt, 1);
    check("parity_no_change", {31'd0, enable_scandoubling}, 32'd0);
    send_byte(8'h7E);
    check("after_err_toggle", {31'd0, enable_scandoubling}, 32'd1);

    send_byte(8'hF0);
    send_byte(8'h77);
    chk_en = 0;
    send_frame(8'h77, 1'b0, 5);
    chk_en = 1;
    repeat (7000) @(negedge clk6);
    send_byte(8'h77);
    check("timeout_77", {31'd0, disable_scaneffect}, 32'd1);

    send_byte(8'hF0);
    send_byte(8'h77);
    for (int g = 0; g < 5; g++) begin
      clkps2 = 0;
      repeat (2) @(negedge clk6);
      clkps2 = 1;
      repeat (20) @(negedge clk6);
    end
    send_byte(8'h77);
    check("glitch_77", {31'd0, disable_scaneffect}, 32'd0);
    check("err_total", err_cnt, 1);

    do_reset(8'h02, 2);
    boot_len("boot_len_run_reset");
    check("run_reset_outs", {30'd0, enable_scandoubling, disable_scaneffect}, 32'b00);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
Owns the scandoubler control pair (enable_scandoubling, disable_scaneffect) that feeds the VGA scandoubler. After reset it performs a one-shot boot read of a config byte from SRAM, then watches the PS/2 line for hotkeys that toggle video modes at runtime. The PS/2 monitoring is passive: it only samples the keyboard lines and never drives them.

Parameters:
CFG_ADDR, 21'h008FD5, SRAM address of the boot config byte.
SETTLE_CYCLES, 64, number of clk6 cycles the boot read holds the SRAM address before sampling.
PS2_TIMEOUT, 6000, idle clk6 cycles (1 ms) after which a partial PS/2 frame is discarded.
FILTER_LEN, 8, depth of the PS/2 clock glitch filter.

Ports:
clk6  input  1  6 MHz system clock; the only clock.
master_reset_n  input  1  synchronous, active-low reset.
clkps2  input  1  PS/2 clock, sampled only (line is shared with the keyboard core).
dataps2  input  1  PS/2 data, sampled only.
sram_data_in  input  8  SRAM data bus, read during boot.
cfg_addr  output  21  constant CFG_ADDR; top muxes it onto SRAM while cfg_rd_active=1.
cfg_rd_active  output  1  high while the boot read owns SRAM (forces we_n=1 at top).
cfg_done  output  1  boot read complete.
enable_scandoubling  output  1  mode bit 0.
disable_scaneffect  output  1  inverse of mode bit 1.

Behaviour:
- Decided: one clock (clk6); reset (master_reset_n) is synchronous and active-low. All state is in the clk6 domain.
- Reset values: mode=2'b00, so enable_scandoubling=0 and disable_scaneffect=1. Also cfg_rd_active=1, cfg_done=0, state=BOOT, counter=0, held flags=0, prefix flags=0.
- FSM BOOT: counter increments each cycle; cfg_rd_active=1.
  - On the cycle counter==SETTLE_CYCLES-1: mode<=sram_data_in[1:0], and the next state is RUN.
  - cfg_rd_active is high for exactly SETTLE_CYCLES cycles after reset release.
- FSM RUN: cfg_rd_active=0, cfg_done=1. Stays in RUN until reset.
- Reset asserted mid-BOOT or in RUN: returns to BOOT, counter=0, and the boot read is redone in full.
- Outputs are registered: enable_scandoubling=mode[0], disable_scaneffect=~mode[1]. They update 1 cycle after mode changes.
- PS/2 receive (ps2_rx):
  - Filter: clkps2 is shifted into a FILTER_LEN-bit register. The filtered level goes 1 only on all-ones and 0 only on all-zeros.
  - A falling edge of the filtered clock samples dataps2.
  - Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
  - A valid frame emits rx_byte plus a 1-cycle rx_strobe.
  - Bad start, parity or stop: frame dropped, no strobe, and a 1-cycle rx_err is pulsed.
  - Idle counter is cleared on every filtered edge. When it reaches PS2_TIMEOUT, the bit count resets to 0.
- Scancode decode (RUN only; strobes arriving during BOOT are discarded):
  - 0xF0 sets brk. 0xE0 sets ext. Any other byte is a final code; brk and ext are cleared after it is processed.
  - Final code with ext=1: ignored. This covers E0 7E, the Ctrl+Break sequence.
  - 0x7E (Scroll Lock), brk=0, held_sl=0: toggle mode[0], set held_sl. With brk=1: clear held_sl.
  - 0x77 (Num Lock), brk=0, held_nl=0: toggle mode[1], set held_nl. With brk=1: clear held_nl.
  - Typematic repeats (make code while held) cause no toggle.
  - rx_err clears brk and ext.
- If a strobe and the BOOT→RUN transition fall on the same cycle, the byte is discarded.
- Worst-case latency from stop-bit edge to output change is 3 cycles.

Decomposition:
- Package video_mode_pkg holds:
  - scancode constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_SCROLL=8'h7E, SC_NUMLOCK=8'h77;
  - state encoding BOOT/RUN;
  - default CFG_ADDR.
- One sub-module, ps2_rx: filter, edge detect, 11-bit shifter, parity check, timeout. Ports are clk6, master_reset_n, clkps2, dataps2, rx_byte[7:0], rx_strobe, rx_err.

Test Plan:
- Boot read: sram_data_in=8'h03, release reset → cfg_rd_active high for exactly 64 cycles; then enable_scandoubling=1, disable_scaneffect=0, cfg_done=1.
- Scroll Lock: from mode 00, send frames 7E, 7E, 7E (typematic) → enable_scandoubling toggles to 1 once only. Then send F0 7E, 7E → it toggles back to 0.
- Num Lock plus extended code: send 77 → disable_scaneffect goes 1→0. Send E0 7E → no change on either output.
- Parity error: a 7E frame with even parity → rx_err pulses and mode is unchanged. A following valid 7E toggles bit 0.
- Timeout: send 5 bits of a frame, idle 7000 cycles, then a full 77 frame → 77 is decoded correctly. Also inject 2-cycle glitches on clkps2 → no extra bits are captured.
- Reset mid-operation: assert master_reset_n=0 at cycle 30 of BOOT (and again in RUN with mode=11) → on release, the outputs show reset values, and a fresh 64-cycle read loads the new sram_data_in=8'h02.
